reg_list_sequencer: RTL and testbench

- Walks an 8-bit register-list mask for multi-register load/store, one register per memory transfer.
- Selects registers lowest-index first, using the same priority order as the existing register priority encoder. Priority selection is built in.
- Issues one memory request per selected register with an incrementing address and a req/ready handshake.
- Sits between instruction decode, which supplies the mask and base address, and the register file/memory port.

---
 rtl/reg_list_sequencer.sv | 101 ++++++++++
 tb/tb_reg_list_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_list_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_list_sequencer                                              |
// | Purpose  : Walks an 8-bit register mask lowest-index first, issuing one    |
// |            memory request per selected register at incrementing addresses. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module reg_list_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic [2:0]        reg_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              done,
  output logic [3:0]        count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_step = ADDR_W'(ADDR_STEP);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_pending, w_pending_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [3:0]        r_count, w_count_nxt;
  logic [2:0]        w_idx;

  // Descending scan so the lowest set bit is the last (winning) assignment.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pending[i]) w_idx = 3'(i);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_addr_nxt    = r_addr;
    w_count_nxt   = r_count;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        if (start) begin
          w_count_nxt = 4'd0;
          if (reg_list != 8'd0) begin
            w_pending_nxt = reg_list;
            w_addr_nxt    = base_addr;
            w_state_nxt   = S_ISSUE;
          end else begin
            w_state_nxt   = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          w_pending_nxt = r_pending & ~(8'd1 << w_idx);
          w_addr_nxt    = r_addr + c_step;
          w_count_nxt   = r_count + 4'd1;
          if (w_pending_nxt == 8'd0) w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= 8'd0;
      r_addr    <= '0;
      r_count   <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_addr    <= w_addr_nxt;
      r_count   <= w_count_nxt;
    end
  end

  assign mem_req  = (r_state == S_ISSUE);
  assign busy     = (r_state == S_ISSUE);
  assign done     = (r_state == S_DONE);
  assign reg_idx  = w_idx;
  assign mem_addr = r_addr;
  assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_list_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_reg_list_sequencer                                           |
// | Purpose  : Randomized self-checking bench against a transfer-list model.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_reg_list_sequencer;

  localparam int c_addr_w = 16;
  localparam int c_step   = 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [7:0]          reg_list = 8'd0;
  logic [c_addr_w-1:0] base_addr = '0;
  logic                mem_ready = 1'b0;
  logic                mem_req;
  logic [2:0]          reg_idx;
  logic [c_addr_w-1:0] mem_addr;
  logic                busy;
  logic                done;
  logic [3:0]          count;

  int total = 0;
  int bad   = 0;
  int               r_exp_count = 0;
  logic [c_addr_w-1:0] r_exp_addr = '0;

  reg_list_sequencer #(.ADDR_W(c_addr_w), .ADDR_STEP(c_step)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reg_list  (reg_list),
    .base_addr (base_addr),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .reg_idx   (reg_idx),
    .mem_addr  (mem_addr),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 random ready, 1 ready always high, 2 ready toggles starting low.
  // poke: raise start with a different mask while the sequence is busy.
  task automatic run_seq(input logic [7:0] mask, input logic [c_addr_w-1:0] base,
                         input int mode, input bit poke);
    int q_idx[$];
    int n   = 0;
    int cyc = 0;
    bit rdy;
    logic [c_addr_w-1:0] ea;
    for (int i = 0; i < 8; i++) if (mask[i]) q_idx.push_back(i);
    start = 1'b1; reg_list = mask; base_addr = base;
    tick();
    start = 1'b0; reg_list = 8'($urandom); base_addr = c_addr_w'($urandom);
    while (q_idx.size() != 0 && cyc < 200) begin
      ea = base + c_addr_w'(n * c_step);
      check_val("req",   32'(mem_req), 32'd1);
      check_val("busy",  32'(busy), 32'd1);
      check_val("done",  32'(done), 32'd0);
      check_val("idx",   32'(reg_idx), 32'(q_idx[0]));
      check_val("addr",  32'(mem_addr), 32'(ea));
      check_val("count", 32'(count), 32'(n));
      if (poke && cyc == 0) begin
        start = 1'b1; reg_list = 8'h0F; base_addr = 16'h5555;
      end
      case (mode)
        0:       rdy = 1'($urandom_range(0, 1));
        1:       rdy = 1'b1;
        default: rdy = cyc[0];
      endcase
      mem_ready = rdy;
      tick();
      start = 1'b0;
      if (rdy) begin
        void'(q_idx.pop_front());
        n++;
      end
      cyc++;
    end
    if (q_idx.size() != 0) check_val("timeout", 32'd0, 32'd1);
    mem_ready = 1'b0;
    r_exp_count = $countones(mask);
    r_exp_addr  = (mask == 8'd0) ? r_exp_addr : base + c_addr_w'(r_exp_count * c_step);
    check_val("end_done",  32'(done), 32'd1);
    check_val("end_busy",  32'(busy), 32'd0);
    check_val("end_req",   32'(mem_req), 32'd0);
    check_val("end_count", 32'(count), 32'(r_exp_count));
    check_val("end_addr",  32'(mem_addr), 32'(r_exp_addr));
  endtask

  task automatic idle_cycle();
    tick();
    check_val("idle_done",  32'(done), 32'd0);
    check_val("idle_busy",  32'(busy), 32'd0);
    check_val("idle_req",   32'(mem_req), 32'd0);
    check_val("idle_count", 32'(count), 32'(r_exp_count));
    check_val("idle_addr",  32'(mem_addr), 32'(r_exp_addr));
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_req"},   32'(mem_req), 32'd0);
    check_val({tag, "_busy"},  32'(busy), 32'd0);
    check_val({tag, "_done"},  32'(done), 32'd0);
    check_val({tag, "_count"}, 32'(count), 32'd0);
    check_val({tag, "_idx"},   32'(reg_idx), 32'd0);
    check_val({tag, "_addr"},  32'(mem_addr), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    check_reset_vals("rst");
    rst = 1'b0;
    tick();
    check_reset_vals("idle");

    run_seq(8'b1000_0101, 16'h0100, 1, 1'b0);
    idle_cycle();
    run_seq(8'hFF, 16'hFFFE, 2, 1'b0);
    idle_cycle();
    run_seq(8'h00, 16'h1234, 1, 1'b0);
    idle_cycle();
    run_seq(8'h30, 16'h0200, 0, 1'b1);
    run_seq(8'h40, 16'h0020, 1, 1'b0);
    idle_cycle();

    // Reset in the middle of a sequence, after its first handshake.
    start = 1'b1; reg_list = 8'h0E; base_addr = 16'h1234;
    tick();
    start = 1'b0;
    check_val("mid_idx0", 32'(reg_idx), 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_val("mid_idx1",  32'(reg_idx), 32'd2);
    check_val("mid_addr1", 32'(mem_addr), 32'h1235);
    check_val("mid_count", 32'(count), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    r_exp_count = 0;
    r_exp_addr  = '0;
    run_seq(8'h01, 16'h0777, 1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] m;
      m = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_seq(m, c_addr_w'($urandom), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
